dmem_arbiter: RTL and testbench

- Shares the single-port data RAM (ram_golden, 1024x32, synchronous read) between two requesters: the pipelined core data port and a loader/debug port used by the bench to preload or inspect memory.
- Core port has fixed priority. A starvation counter guarantees the loader a grant after STARVE_LIMIT consecutive denied cycles.
- Read data is steered back to the issuing port with a one-cycle tagged response pipeline.
- Sits between the core's daddr/d_rw/ddata_w/ddata_r and the RAM wrapper.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/arb_starve_ctr.sv | 31 +++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the core
// data port and the loader/debug port.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CORE   = 2'd1,
        OWN_LOADER = 2'd2
    } owner_t;

    typedef enum logic {
        PRIO_CORE    = 1'b0,
        BOOST_LOADER = 1'b1
    } arb_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive cycles in which the loader asks but is not granted.
// near_limit flags that one more denied cycle reaches LIMIT.
module arb_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         near_limit
);

    localparam logic [W-1:0] LIM    = W'(LIMIT);
    localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

    // Exposed independently of inc so the grant logic can use it without a loop.
    assign near_limit = (cnt == LIM_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority arbiter sharing the single-port data RAM between the core and
// the loader, with starvation boost and a one-cycle tagged read-response path.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              c_req,
    input  logic              c_rw,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_rw,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] daddr,
    output logic              d_rw,
    output logic [DATA_W-1:0] ddata_w,
    input  logic [DATA_W-1:0] ddata_r,
    output logic [CNT_W-1:0]  conflict_cnt,
    output arb_state_t        dbg_state
);

    // Handshake: a requester holds req/rw/addr/wdata stable until it sees gnt in
    // the same cycle; gnt is the accept. A granted read returns rvalid/rdata on
    // the issuing port exactly one cycle later, with no backpressure.

    arb_state_t   state, state_next;
    owner_t       owner, owner_next;
    logic [3:0]   starve_cnt;
    logic         starve_near;
    logic         starve_inc;
    logic         starve_clr;

    assign starve_inc = l_req & ~l_gnt;
    assign starve_clr = l_gnt | ~l_req;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .W     (4)
    ) u_starve (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .inc        (starve_inc),
        .clr        (starve_clr),
        .cnt        (starve_cnt),
        .near_limit (starve_near)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= PRIO_CORE;
            owner <= OWN_NONE;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    // Grants are gated by RESET_N so nothing reaches the RAM while in reset.
    always_comb begin
        state_next = state;
        c_gnt      = 1'b0;
        l_gnt      = 1'b0;
        if (RESET_N) begin
            case (state)
                PRIO_CORE: begin
                    if (c_req) begin
                        c_gnt = 1'b1;
                    end else if (l_req) begin
                        l_gnt = 1'b1;
                    end
                    if (l_req && !l_gnt && starve_near) begin
                        state_next = BOOST_LOADER;
                    end
                end
                BOOST_LOADER: begin
                    l_gnt      = l_req;
                    state_next = PRIO_CORE;
                end
                default: state_next = PRIO_CORE;
            endcase
        end
    end

    always_comb begin
        daddr      = '0;
        d_rw       = RW_READ;
        ddata_w    = '0;
        owner_next = OWN_NONE;
        if (c_gnt) begin
            daddr   = c_addr;
            d_rw    = c_rw;
            ddata_w = c_wdata;
            if (c_rw == RW_READ) owner_next = OWN_CORE;
        end else if (l_gnt) begin
            daddr   = l_addr;
            d_rw    = l_rw;
            ddata_w = l_wdata;
            if (l_rw == RW_READ) owner_next = OWN_LOADER;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            conflict_cnt <= '0;
        end else if (c_req && l_req && !(&conflict_cnt)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    assign c_rvalid  = (owner == OWN_CORE);
    assign l_rvalid  = (owner == OWN_LOADER);
    assign c_rdata   = c_rvalid ? ddata_r : '0;
    assign l_rdata   = l_rvalid ? ddata_r : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural sync-read RAM, driver task with
// per-cycle grant expectations, and a queue-based monitor for read responses.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    logic        CLK;
    logic        RESET_N;
    logic        c_req, c_rw, l_req, l_rw;
    logic [9:0]  c_addr, l_addr;
    logic [31:0] c_wdata, l_wdata;
    logic        c_gnt, c_rvalid, l_gnt, l_rvalid;
    logic [31:0] c_rdata, l_rdata;
    logic [9:0]  daddr;
    logic        d_rw;
    logic [31:0] ddata_w, ddata_r;
    logic [15:0] conflict_cnt;
    arb_state_t  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [32:0] exp_q[$];
    int          due_q[$];

    dmem_arbiter dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .c_req        (c_req),
        .c_rw         (c_rw),
        .c_addr       (c_addr),
        .c_wdata      (c_wdata),
        .c_gnt        (c_gnt),
        .c_rvalid     (c_rvalid),
        .c_rdata      (c_rdata),
        .l_req        (l_req),
        .l_rw         (l_rw),
        .l_addr       (l_addr),
        .l_wdata      (l_wdata),
        .l_gnt        (l_gnt),
        .l_rvalid     (l_rvalid),
        .l_rdata      (l_rdata),
        .daddr        (daddr),
        .d_rw         (d_rw),
        .ddata_w      (ddata_w),
        .ddata_r      (ddata_r),
        .conflict_cnt (conflict_cnt),
        .dbg_state    (dbg_state)
    );

    // Clock and behavioural RAM (read-first, one-cycle read latency)
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] mem [1024];
    always @(posedge CLK) begin
        if (d_rw) mem[daddr] <= ddata_w;
        ddata_r <= mem[daddr];
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One arbitration cycle: apply inputs, check grants/RAM side at negedge,
    // queue the expected read response, advance to just after the next posedge.
    task automatic step(input logic cr, input logic crw, input logic [9:0] ca, input logic [31:0] cw,
                        input logic lr, input logic lrw, input logic [9:0] la, input logic [31:0] lw,
                        input logic exp_cg, input logic exp_lg, input arb_state_t exp_st,
                        input logic [31:0] exp_rd, input logic push_rsp = 1'b1);
        logic [9:0] ea;
        logic       erw;
        c_req = cr; c_rw = crw; c_addr = ca; c_wdata = cw;
        l_req = lr; l_rw = lrw; l_addr = la; l_wdata = lw;
        ea  = exp_cg ? ca : (exp_lg ? la : 10'd0);
        erw = exp_cg ? crw : (exp_lg ? lrw : 1'b0);
        @(negedge CLK);
        chk("c_gnt", c_gnt, exp_cg);
        chk("l_gnt", l_gnt, exp_lg);
        chk("daddr", daddr, ea);
        chk("d_rw", d_rw, erw);
        if (erw) chk("ddata_w", ddata_w, exp_cg ? cw : lw);
        chk("state", dbg_state, exp_st);
        if (push_rsp && exp_cg && crw == RD) begin
            exp_q.push_back({1'b0, exp_rd});
            due_q.push_back(cyc + 1);
        end else if (push_rsp && exp_lg && lrw == RD) begin
            exp_q.push_back({1'b1, exp_rd});
            due_q.push_back(cyc + 1);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(0, RD, 10'd0, 32'd0, 0, RD, 10'd0, 32'd0, 0, 0, PRIO_CORE, 32'd0);
    endtask

    // Response monitor: a due entry demands rvalid on the right port this cycle
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                logic [32:0] e;
                e = exp_q.pop_front();
                void'(due_q.pop_front());
                chk("rsp_c_rvalid", c_rvalid, !e[32]);
                chk("rsp_l_rvalid", l_rvalid, e[32]);
                chk("rsp_rdata", e[32] ? l_rdata : c_rdata, e[31:0]);
                chk("rsp_idle_rdata", e[32] ? c_rdata : l_rdata, 32'd0);
            end else if (c_rvalid || l_rvalid) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid actual c=%0b l=%0b expected none at %0t",
                         c_rvalid, l_rvalid, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        c_req = 0; c_rw = 0; c_addr = '0; c_wdata = '0;
        l_req = 0; l_rw = 0; l_addr = '0; l_wdata = '0;
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        #1;
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_l_gnt", l_gnt, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_l_rvalid", l_rvalid, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_d_rw", d_rw, 0);
        chk("rst_conflict", conflict_cnt, 0);
        chk("rst_state", dbg_state, PRIO_CORE);
        idle();

        // Core write then read back
        step(1, WR, 10'h010, 32'hDEADBEEF, 0, RD, 10'd0, 32'd0, 1, 0, PRIO_CORE, 32'd0);
        step(1, RD, 10'h010, 32'd0,        0, RD, 10'd0, 32'd0, 1, 0, PRIO_CORE, 32'hDEADBEEF);
        idle();

        // Loader write then read back with the core idle
        step(0, RD, 10'd0, 32'd0, 1, WR, 10'h3FF, 32'h12345678, 0, 1, PRIO_CORE, 32'd0);
        step(0, RD, 10'd0, 32'd0, 1, RD, 10'h3FF, 32'd0,        0, 1, PRIO_CORE, 32'h12345678);
        idle();

        // Preload the alternating-read words
        step(1, WR, 10'h001, 32'h0000000A, 0, RD, 10'd0, 32'd0, 1, 0, PRIO_CORE, 32'd0);
        step(0, RD, 10'd0, 32'd0, 1, WR, 10'h002, 32'h0000000B, 0, 1, PRIO_CORE, 32'd0);

        // Ten cycles of contention: loader boosted on cycles 4 and 9
        for (int i = 0; i < 10; i++) begin
            logic boost;
            boost = (i == 4) || (i == 9);
            step(1, RD, 10'h001, 32'd0, 1, RD, 10'h002, 32'd0, !boost, boost,
                 boost ? BOOST_LOADER : PRIO_CORE, boost ? 32'h0000000B : 32'h0000000A);
        end
        idle();
        chk("conflict_10", conflict_cnt, 16'd10);

        // Alternating single-requester reads every cycle
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                step(1, RD, 10'h001, 32'd0, 0, RD, 10'd0, 32'd0, 1, 0, PRIO_CORE, 32'h0000000A);
            else
                step(0, RD, 10'd0, 32'd0, 1, RD, 10'h002, 32'd0, 0, 1, PRIO_CORE, 32'h0000000B);
        end
        idle();

        // Loader drops its request while boosted: no grant that cycle
        for (int i = 0; i < 4; i++)
            step(1, RD, 10'h001, 32'd0, 1, RD, 10'h002, 32'd0, 1, 0, PRIO_CORE, 32'h0000000A);
        step(1, RD, 10'h001, 32'd0, 0, RD, 10'd0, 32'd0, 0, 0, BOOST_LOADER, 32'd0);
        step(1, RD, 10'h001, 32'd0, 0, RD, 10'd0, 32'd0, 1, 0, PRIO_CORE, 32'h0000000A);

        // A gap in l_req clears the starve count, so no boost within 3+3 cycles
        for (int i = 0; i < 8; i++) begin
            logic lr;
            lr = (i != 3) && (i != 7);
            step(1, RD, 10'h001, 32'd0, lr, RD, 10'h002, 32'd0, 1, 0, PRIO_CORE, 32'h0000000A);
        end
        idle();
        chk("conflict_20", conflict_cnt, 16'd20);

        // Reset pulse while a core read is in flight: its response is dropped
        step(1, RD, 10'h010, 32'd0, 0, RD, 10'd0, 32'd0, 1, 0, PRIO_CORE, 32'd0, 1'b0);
        RESET_N = 1'b0;
        c_req = 1; c_rw = RD; l_req = 1; l_rw = WR; l_addr = 10'h005; l_wdata = 32'hFFFFFFFF;
        #1;
        chk("inrst_c_gnt", c_gnt, 0);
        chk("inrst_l_gnt", l_gnt, 0);
        chk("inrst_d_rw", d_rw, 0);
        chk("inrst_daddr", daddr, 0);
        chk("inrst_ddata_w", ddata_w, 0);
        chk("inrst_c_rvalid", c_rvalid, 0);
        #4;
        RESET_N = 1'b1;
        c_req = 0; l_req = 0;
        #1;
        chk("postrst_c_rvalid", c_rvalid, 0);
        chk("postrst_state", dbg_state, PRIO_CORE);
        chk("postrst_conflict", conflict_cnt, 0);
        @(posedge CLK);
        #1;
        idle();

        // Normal operation resumes after reset
        step(1, RD, 10'h010, 32'd0, 0, RD, 10'd0, 32'd0, 1, 0, PRIO_CORE, 32'hDEADBEEF);
        idle();
        idle();

        chk("rsp_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
